// File: rtl/cpu_instr_loader_pkg.sv
// Shared types and constants for the cpu instruction loader.
package cpu_loader_pkg;

    // Instruction width seen by the cpu core.
    localparam int INSTR_W = 9;

    // Byte assembler: waiting for the low byte, or holding it and waiting for the high beat.
    typedef enum logic {
        LO,
        HI
    } asm_state_t;

    // Issue sequencer: idle, driving the write_en pulse, or pacing before the next issue.
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP
    } iss_state_t;

    // Counter width able to hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cpu_instr_loader_if.sv
// Pin-side byte input, control, and cpu-side instruction/status bundle.
interface cpu_instr_loader_if #(
    parameter int DEPTH = 4
) ();
    import cpu_loader_pkg::*;

    logic [7:0]                  IN_BYTE;
    logic                        IN_STB;
    logic                        FLUSH;
    logic                        HALT;
    logic [INSTR_W-1:0]          INSTRUCTION;
    logic                        write_en;
    logic [cnt_width(DEPTH)-1:0] FIFO_COUNT;
    logic                        FULL;
    logic                        OVERFLOW;
    logic                        BUSY;

    // Drives the pins and control, observes the cpu-side outputs.
    modport master (
        output IN_BYTE, IN_STB, FLUSH, HALT,
        input  INSTRUCTION, write_en, FIFO_COUNT, FULL, OVERFLOW, BUSY
    );

    // The loader itself.
    modport slave (
        input  IN_BYTE, IN_STB, FLUSH, HALT,
        output INSTRUCTION, write_en, FIFO_COUNT, FULL, OVERFLOW, BUSY
    );
endinterface

// File: rtl/cpu_instr_loader_fifo.sv
// DEPTH x INSTR_W synchronous FIFO with show-ahead head output.
module instr_fifo
    import cpu_loader_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = cnt_width(DEPTH),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [INSTR_W-1:0] din,
    output logic [INSTR_W-1:0] dout,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic               empty
);
    logic [INSTR_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr_reg;
    logic [AW-1:0]      rd_ptr_reg;
    logic [CW-1:0]      count_reg;
    logic               do_push;
    logic               do_pop;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    // A pop frees a slot in the same edge, so a push into a full FIFO is still accepted then.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop) && !flush;

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers wrap naturally modulo DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (do_push && !do_pop)      count_reg <= count_reg + CW'(1);
            else if (do_pop && !do_push) count_reg <= count_reg - CW'(1);
        end
    end

    assign dout  = mem[rd_ptr_reg];
    assign count = count_reg;
endmodule

// File: rtl/cpu_instr_loader.sv
// Assembles 9-bit instructions from two byte beats, buffers them, and issues
// them to the cpu as paced one-cycle write_en pulses.
module cpu_instr_loader
    import cpu_loader_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ISSUE_GAP = 2
) (
    input  logic            CLK,
    input  logic            RESET,
    cpu_instr_loader_if.slave bus
);
    localparam int CW       = cnt_width(DEPTH);
    localparam int GAP_W    = $clog2(ISSUE_GAP + 1) + 1;
    // The IDLE cycle that precedes the next issue is the last idle cycle of the
    // gap, so GAP itself lasts ISSUE_GAP-1 cycles (loaded as ISSUE_GAP-2).
    localparam int GAP_LOAD = (ISSUE_GAP >= 2) ? ISSUE_GAP - 2 : 0;

    asm_state_t         asm_state_reg, asm_state_next;
    logic [7:0]         lo_reg, lo_next;
    iss_state_t         iss_state_reg, iss_state_next;
    logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
    logic [INSTR_W-1:0] instr_reg, instr_next;
    logic               wr_en_reg, wr_en_next;
    logic               overflow_reg, overflow_next;

    logic               push, pop;
    logic [INSTR_W-1:0] head;
    logic [CW-1:0]      count;
    logic               full, empty;

    instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (push),
        .pop   (pop),
        .flush (bus.FLUSH),
        .din   ({bus.IN_BYTE[0], lo_reg}),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // State register for both FSMs and the issued-instruction outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            asm_state_reg <= LO;
            lo_reg        <= '0;
            iss_state_reg <= IDLE;
            gap_cnt_reg   <= '0;
            instr_reg     <= '0;
            wr_en_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            asm_state_reg <= asm_state_next;
            lo_reg        <= lo_next;
            iss_state_reg <= iss_state_next;
            gap_cnt_reg   <= gap_cnt_next;
            instr_reg     <= instr_next;
            wr_en_reg     <= wr_en_next;
            overflow_reg  <= overflow_next;
        end
    end

    // Next-state logic: issue decision first, since a same-edge pop lets a push into a full FIFO.
    always_comb begin
        asm_state_next = asm_state_reg;
        lo_next        = lo_reg;
        iss_state_next = iss_state_reg;
        gap_cnt_next   = gap_cnt_reg;
        instr_next     = instr_reg;
        wr_en_next     = 1'b0;
        overflow_next  = overflow_reg;
        push           = 1'b0;
        pop            = 1'b0;

        if (bus.FLUSH) begin
            // INSTRUCTION deliberately keeps its last value.
            asm_state_next = LO;
            iss_state_next = IDLE;
            gap_cnt_next   = '0;
            overflow_next  = 1'b0;
        end else begin
            case (iss_state_reg)
                IDLE: begin
                    if (!empty && !bus.HALT) begin
                        pop            = 1'b1;
                        instr_next     = head;
                        wr_en_next     = 1'b1;
                        iss_state_next = ISSUE;
                    end
                end
                ISSUE: begin
                    if (ISSUE_GAP == 0) begin
                        if (!empty && !bus.HALT) begin
                            pop        = 1'b1;
                            instr_next = head;
                            wr_en_next = 1'b1;
                        end else begin
                            iss_state_next = IDLE;
                        end
                    end else if (ISSUE_GAP == 1) begin
                        iss_state_next = IDLE;
                    end else begin
                        iss_state_next = GAP;
                        gap_cnt_next   = GAP_W'(GAP_LOAD);
                    end
                end
                GAP: begin
                    if (gap_cnt_reg == '0) iss_state_next = IDLE;
                    else                   gap_cnt_next   = gap_cnt_reg - GAP_W'(1);
                end
                default: iss_state_next = IDLE;
            endcase

            case (asm_state_reg)
                LO: begin
                    if (bus.IN_STB) begin
                        lo_next        = bus.IN_BYTE;
                        asm_state_next = HI;
                    end
                end
                HI: begin
                    if (bus.IN_STB) begin
                        push           = 1'b1;
                        asm_state_next = LO;
                        if (full && !pop) overflow_next = 1'b1;
                    end
                end
                default: asm_state_next = LO;
            endcase
        end
    end

    assign bus.INSTRUCTION = instr_reg;
    assign bus.write_en    = wr_en_reg;
    assign bus.FIFO_COUNT  = count;
    assign bus.FULL        = full;
    assign bus.OVERFLOW    = overflow_reg;
    assign bus.BUSY        = !empty || (asm_state_reg == HI) || (iss_state_reg != IDLE);
endmodule

// File: tb/tb_cpu_instr_loader.sv
// Scoreboard bench: two loaders (ISSUE_GAP=2 and 0) share one stimulus stream;
// a queue-based reference model predicts issues and status for each.
module tb_cpu_instr_loader;
    import cpu_loader_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = cnt_width(DEPTH);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_byte = '0;
    logic       in_stb = 1'b0;
    logic       flush = 1'b0;
    logic       halt = 1'b0;

    always #5 clk = ~clk;

    cpu_instr_loader_if #(.DEPTH(DEPTH)) bus0 ();
    cpu_instr_loader_if #(.DEPTH(DEPTH)) bus1 ();

    assign bus0.IN_BYTE = in_byte;
    assign bus0.IN_STB  = in_stb;
    assign bus0.FLUSH   = flush;
    assign bus0.HALT    = halt;
    assign bus1.IN_BYTE = in_byte;
    assign bus1.IN_STB  = in_stb;
    assign bus1.FLUSH   = flush;
    assign bus1.HALT    = halt;

    cpu_instr_loader #(.DEPTH(DEPTH), .ISSUE_GAP(2)) dut0 (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus0.slave)
    );
    cpu_instr_loader #(.DEPTH(DEPTH), .ISSUE_GAP(0)) dut1 (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus1.slave)
    );

    logic [8:0]    o_instr [2];
    logic          o_we    [2];
    logic [CW-1:0] o_cnt   [2];
    logic          o_full  [2];
    logic          o_ovf   [2];
    logic          o_busy  [2];

    assign o_instr[0] = bus0.INSTRUCTION;
    assign o_we[0]    = bus0.write_en;
    assign o_cnt[0]   = bus0.FIFO_COUNT;
    assign o_full[0]  = bus0.FULL;
    assign o_ovf[0]   = bus0.OVERFLOW;
    assign o_busy[0]  = bus0.BUSY;
    assign o_instr[1] = bus1.INSTRUCTION;
    assign o_we[1]    = bus1.write_en;
    assign o_cnt[1]   = bus1.FIFO_COUNT;
    assign o_full[1]  = bus1.FULL;
    assign o_ovf[1]   = bus1.OVERFLOW;
    assign o_busy[1]  = bus1.BUSY;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [8:0] v;
        int         cyc;
    } exp_t;

    exp_t       eq [2][$];    // expected write_en pulses (value, edge index)
    logic [8:0] mq [2][$];    // modelled FIFO contents
    logic       half    [2];
    logic [7:0] lo_m    [2];
    logic       ovf_m   [2];
    logic [8:0] last_m  [2];
    int         next_ok [2];  // earliest edge at which the next issue may happen
    int         busy_until [2];
    int         gapv    [2] = '{2, 0};
    int         cyc = 0;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            eq[k].delete();
            mq[k].delete();
            half[k]       = 1'b0;
            lo_m[k]       = '0;
            ovf_m[k]      = 1'b0;
            last_m[k]     = '0;
            next_ok[k]    = 0;
            busy_until[k] = 0;
        end
    endtask

    // Model step: evaluated from the input values seen at each rising edge.
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if (flush) begin
                    mq[k].delete();
                    half[k]       = 1'b0;
                    ovf_m[k]      = 1'b0;
                    next_ok[k]    = 0;
                    busy_until[k] = 0;
                end else begin
                    if (mq[k].size() > 0 && !halt && cyc >= next_ok[k]) begin
                        last_m[k] = mq[k].pop_front();
                        eq[k].push_back('{v: last_m[k], cyc: cyc});
                        next_ok[k]    = cyc + gapv[k] + 1;
                        busy_until[k] = cyc + ((gapv[k] > 1) ? gapv[k] : 1);
                    end
                    if (in_stb) begin
                        if (half[k]) begin
                            half[k] = 1'b0;
                            if (mq[k].size() == DEPTH) ovf_m[k] = 1'b1;
                            else mq[k].push_back({in_byte[0], lo_m[k]});
                        end else begin
                            lo_m[k] = in_byte;
                            half[k] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    exp_t mon_e;
    logic mon_exp_we;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (eq[k].size() > 0 && eq[k][0].cyc < cyc) begin
                mon_e = eq[k].pop_front();
                chk($sformatf("d%0d_missed_pulse", k), 0, int'(mon_e.v));
            end
            mon_exp_we = (eq[k].size() > 0) && (eq[k][0].cyc == cyc);
            chk($sformatf("d%0d_write_en", k), int'(o_we[k]), int'(mon_exp_we));
            if (o_we[k])
                $display("d%0d write_en INSTRUCTION=0x%03h cycle %0d", k, o_instr[k], cyc);
            if (mon_exp_we) begin
                mon_e = eq[k].pop_front();
                chk($sformatf("d%0d_issued_instr", k), int'(o_instr[k]), int'(mon_e.v));
            end else begin
                chk($sformatf("d%0d_instr_hold", k), int'(o_instr[k]), int'(last_m[k]));
            end
            chk($sformatf("d%0d_fifo_count", k), int'(o_cnt[k]), mq[k].size());
            chk($sformatf("d%0d_full", k), int'(o_full[k]), int'(mq[k].size() == DEPTH));
            chk($sformatf("d%0d_overflow", k), int'(o_ovf[k]), int'(ovf_m[k]));
            chk($sformatf("d%0d_busy", k), int'(o_busy[k]),
                int'(mq[k].size() > 0 || half[k] || cyc < busy_until[k]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic put_byte(input logic [7:0] b);
        in_byte = b;
        in_stb  = 1'b1;
        tick();
        in_stb  = 1'b0;
    endtask

    task automatic load(input logic [8:0] v);
        logic [6:0] r;
        r = 7'($urandom);
        put_byte(v[7:0]);
        put_byte({r, v[8]});
    endtask

    initial begin
        int n;
        model_reset();
        #1;
        chk("reset_instr", int'(o_instr[0]), 0);
        chk("reset_we", int'(o_we[0]), 0);
        chk("reset_count", int'(o_cnt[0]), 0);
        chk("reset_full", int'(o_full[0]), 0);
        chk("reset_ovf", int'(o_ovf[0]), 0);
        chk("reset_busy", int'(o_busy[0]), 0);
        idle(2);
        rst = 1'b0;
        idle(2);

        // Single load.
        put_byte(8'h2B);
        put_byte(8'h01);
        idle(8);
        chk("single_instr", int'(o_instr[0]), 9'h12B);
        chk("single_busy", int'(o_busy[0]), 0);

        // Pacing.
        load(9'h001);
        load(9'h0F0);
        load(9'h1FF);
        idle(15);

        // Overflow under HALT.
        halt = 1'b1;
        for (int i = 0; i < 5; i++) load(9'(9'h010 + i));
        idle(2);
        chk("ovf_count", int'(o_cnt[0]), 4);
        chk("ovf_full", int'(o_full[0]), 1);
        chk("ovf_flag", int'(o_ovf[0]), 1);
        halt = 1'b0;
        idle(20);
        chk("ovf_sticky", int'(o_ovf[0]), 1);
        chk("ovf_last_issued", int'(o_instr[0]), 9'h013);

        // Ignored high bits.
        put_byte(8'hFF);
        put_byte(8'hFE);
        idle(6);
        chk("hibits_0ff", int'(o_instr[0]), 9'h0FF);
        put_byte(8'h00);
        put_byte(8'h03);
        idle(6);
        chk("hibits_100", int'(o_instr[0]), 9'h100);

        // Flush mid-assembly, with a strobe in the flush cycle.
        put_byte(8'hAA);
        flush   = 1'b1;
        in_stb  = 1'b1;
        in_byte = 8'h77;
        tick();
        flush   = 1'b0;
        in_stb  = 1'b0;
        chk("flush_ovf_clear", int'(o_ovf[0]), 0);
        chk("flush_count", int'(o_cnt[0]), 0);
        put_byte(8'h05);
        put_byte(8'h00);
        idle(6);
        chk("flush_issued", int'(o_instr[0]), 9'h005);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            in_byte = 8'($urandom);
            in_stb  = ($urandom_range(0, 99) < 55);
            halt    = ($urandom_range(0, 99) < 30);
            flush   = ($urandom_range(0, 99) < 3);
            tick();
        end
        in_stb = 1'b0;
        halt   = 1'b0;
        flush  = 1'b1;
        tick();
        flush  = 1'b0;
        idle(4);

        // Reset mid-pulse with two entries still queued.
        halt = 1'b1;
        load(9'h0A1);
        load(9'h0A2);
        load(9'h0A3);
        halt = 1'b0;
        n = 0;
        while (!o_we[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rst_wait_pulse", int'(o_we[0]), 1);
        chk("rst_pre_count", int'(o_cnt[0]), 2);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_async_we", int'(o_we[0]), 0);
        chk("rst_async_instr", int'(o_instr[0]), 0);
        chk("rst_async_count", int'(o_cnt[0]), 0);
        idle(2);
        rst = 1'b0;
        idle(10);
        load(9'h155);
        idle(6);
        chk("post_rst_instr", int'(o_instr[0]), 9'h155);

        // Drain, bounded.
        n = 0;
        while ((eq[0].size() > 0 || eq[1].size() > 0 || mq[0].size() > 0 || mq[1].size() > 0) && n < 60) begin
            tick();
            n++;
        end
        chk("drain_d0", eq[0].size() + mq[0].size(), 0);
        chk("drain_d1", eq[1].size() + mq[1].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
